// File: rtl/frame_threshold_ctrl_pkg.sv
// Shared widths, grade limits, key-FSM encoding and the grade-to-threshold
// mapping used by the key-driven threshold controller.
package frame_threshold_ctrl_pkg;

   localparam int GRADE_W = 4;
   localparam int THR_W   = 8;

   localparam logic [GRADE_W-1:0] GRADE_MAX = 4'd15;
   localparam logic [GRADE_W-1:0] GRADE_MIN = 4'd0;

   typedef logic [1:0] key_state_t;

   localparam logic [1:0] KEY_IDLE   = 2'd0;
   localparam logic [1:0] KEY_HOLD   = 2'd1;
   localparam logic [1:0] KEY_REPEAT = 2'd2;

   typedef struct packed {
      logic [GRADE_W-1:0] grade;
      logic [THR_W-1:0]   thr;
   } commit_t;

   // Threshold for a grade; the caller guarantees the product fits THR_W bits.
   function automatic logic [THR_W-1:0] grade_to_thr(input logic [GRADE_W-1:0] grade,
                                                     input int unsigned thr_step);
      return THR_W'(thr_step * (32'(grade) + 32'd1));
   endfunction

endpackage

// File: rtl/frame_threshold_ctrl_if.sv
// Key, frame-sync and committed-threshold signals between the board side
// (master) and the threshold controller (slave).
interface frame_threshold_ctrl_if;
   import frame_threshold_ctrl_pkg::*;

   logic               key_add_n;
   logic               key_sub_n;
   logic               per_frame_vsync;
   logic [GRADE_W-1:0] Frame_Grade;
   logic [THR_W-1:0]   Frame_Threshold;
   logic [GRADE_W-1:0] pending_grade;
   logic               thr_update;

   modport master (
      output key_add_n,
      output key_sub_n,
      output per_frame_vsync,
      input  Frame_Grade,
      input  Frame_Threshold,
      input  pending_grade,
      input  thr_update
   );

   modport slave (
      input  key_add_n,
      input  key_sub_n,
      input  per_frame_vsync,
      output Frame_Grade,
      output Frame_Threshold,
      output pending_grade,
      output thr_update
   );

endinterface

// File: rtl/key_debounce_repeat.sv
// One push-button: 2-FF synchroniser, debounce counter and hold-to-repeat FSM
// producing single-cycle step pulses and a held flag.
module key_debounce_repeat
   import frame_threshold_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
   parameter int unsigned REPEAT_DELAY    = 50_000_000,
   parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   input  logic suppress_repeat,
   output logic step,
   output logic held
);

   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_W = $clog2(RPT_MAX + 1);

   localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

   generate
      if (DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_timing
         $error("key_debounce_repeat: cycle counts must be non-zero");
      end
   endgenerate

   logic             sync1_reg;
   logic             sync2_reg;
   logic             level_reg;
   logic             level_next;
   logic [DB_W-1:0]  db_cnt_reg;
   logic [DB_W-1:0]  db_cnt_next;
   key_state_t       state_reg;
   key_state_t       state_next;
   logic [RPT_W-1:0] rpt_cnt_reg;
   logic [RPT_W-1:0] rpt_cnt_next;
   logic             step_reg;
   logic             step_next;

   // Count only while the synchronised level disagrees with the accepted one;
   // any return to the accepted level restarts the count.
   always_comb begin
      level_next  = level_reg;
      db_cnt_next = '0;
      if (sync2_reg != level_reg) begin
         if (db_cnt_reg == DB_LAST) begin
            level_next = sync2_reg;
         end else begin
            db_cnt_next = db_cnt_reg + 1'b1;
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      rpt_cnt_next = rpt_cnt_reg;
      step_next    = 1'b0;
      case (state_reg)
         KEY_IDLE: begin
            if (!level_reg) begin
               state_next   = KEY_HOLD;
               rpt_cnt_next = '0;
               step_next    = 1'b1;
            end
         end
         KEY_HOLD: begin
            if (level_reg) begin
               state_next   = KEY_IDLE;
               rpt_cnt_next = '0;
            end else if (rpt_cnt_reg == DELAY_LAST) begin
               state_next   = KEY_REPEAT;
               rpt_cnt_next = '0;
               step_next    = !suppress_repeat;
            end else begin
               rpt_cnt_next = rpt_cnt_reg + 1'b1;
            end
         end
         KEY_REPEAT: begin
            if (level_reg) begin
               state_next   = KEY_IDLE;
               rpt_cnt_next = '0;
            end else if (rpt_cnt_reg == PERIOD_LAST) begin
               rpt_cnt_next = '0;
               step_next    = !suppress_repeat;
            end else begin
               rpt_cnt_next = rpt_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next   = KEY_IDLE;
            rpt_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg   <= 1'b1;
         sync2_reg   <= 1'b1;
         level_reg   <= 1'b1;
         db_cnt_reg  <= '0;
         state_reg   <= KEY_IDLE;
         rpt_cnt_reg <= '0;
         step_reg    <= 1'b0;
      end else begin
         sync1_reg   <= key_n;
         sync2_reg   <= sync1_reg;
         level_reg   <= level_next;
         db_cnt_reg  <= db_cnt_next;
         state_reg   <= state_next;
         rpt_cnt_reg <= rpt_cnt_next;
         step_reg    <= step_next;
      end
   end

   assign step = step_reg;
   assign held = (state_reg != KEY_IDLE);

endmodule

// File: rtl/frame_threshold_ctrl.sv
// Key-driven grade/threshold controller: steps a pending grade from two
// debounced keys and commits it to the binarisation datapath at frame start.
module frame_threshold_ctrl
   import frame_threshold_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
   parameter int unsigned REPEAT_DELAY    = 50_000_000,
   parameter int unsigned REPEAT_PERIOD   = 10_000_000,
   parameter int unsigned GRADE_INIT      = 5,
   parameter int unsigned THR_STEP        = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   frame_threshold_ctrl_if.slave bus
);

   localparam logic [GRADE_W-1:0] INIT_GRADE = GRADE_W'(GRADE_INIT);
   localparam logic [THR_W-1:0]   INIT_THR   = grade_to_thr(INIT_GRADE, THR_STEP);

   generate
      if (THR_STEP * (32'(GRADE_MAX) + 32'd1) > 32'd255) begin : g_thr_overflow
         $error("frame_threshold_ctrl: THR_STEP*(GRADE_MAX+1) does not fit in 8 bits");
      end
      if (GRADE_INIT > 32'(GRADE_MAX)) begin : g_bad_init
         $error("frame_threshold_ctrl: GRADE_INIT out of range");
      end
   endgenerate

   // Index 0 is the add key, index 1 the sub key.
   logic [1:0] keys_n;
   logic [1:0] step;
   logic [1:0] held;

   assign keys_n = {bus.key_sub_n, bus.key_add_n};

   // Each key suppresses its repeats while the other key is also held.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_key
         key_debounce_repeat #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
         ) u_key (
            .clk             (clk),
            .rst_n           (rst_n),
            .key_n           (keys_n[gi]),
            .suppress_repeat (held[1-gi]),
            .step            (step[gi]),
            .held            (held[gi])
         );
      end
   endgenerate

   logic [GRADE_W-1:0] pending_reg;
   logic [GRADE_W-1:0] pending_next;
   commit_t            commit_reg;
   commit_t            commit_next;
   logic               thr_update_reg;
   logic               thr_update_next;
   logic               vsync_reg;
   logic               vsync_rise;
   logic               add_step;
   logic               sub_step;

   // Opposing steps in the same cycle cancel; the grade saturates at both ends.
   always_comb begin
      add_step     = step[0] & ~step[1];
      sub_step     = step[1] & ~step[0];
      pending_next = pending_reg;
      if (add_step && pending_reg != GRADE_MAX) begin
         pending_next = pending_reg + 1'b1;
      end else if (sub_step && pending_reg != GRADE_MIN) begin
         pending_next = pending_reg - 1'b1;
      end
   end

   // The commit takes pending_reg as it stood before this cycle's step, so a
   // step coinciding with frame start is deferred to the next frame.
   always_comb begin
      vsync_rise      = bus.per_frame_vsync & ~vsync_reg;
      commit_next     = commit_reg;
      thr_update_next = 1'b0;
      if (vsync_rise) begin
         commit_next.grade = pending_reg;
         commit_next.thr   = grade_to_thr(pending_reg, THR_STEP);
         thr_update_next   = (pending_reg != commit_reg.grade);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_reg    <= INIT_GRADE;
         commit_reg     <= '{grade: INIT_GRADE, thr: INIT_THR};
         thr_update_reg <= 1'b0;
         vsync_reg      <= 1'b0;
      end else begin
         pending_reg    <= pending_next;
         commit_reg     <= commit_next;
         thr_update_reg <= thr_update_next;
         vsync_reg      <= bus.per_frame_vsync;
      end
   end

   assign bus.Frame_Grade     = commit_reg.grade;
   assign bus.Frame_Threshold = commit_reg.thr;
   assign bus.pending_grade   = pending_reg;
   assign bus.thr_update      = thr_update_reg;

endmodule

// File: tb/tb_frame_threshold_ctrl.sv
// Scenario bench for frame_threshold_ctrl with a timing-rule reference model
// of debounce, hold-to-repeat, saturation and frame-start commit.
module tb_frame_threshold_ctrl;
   import frame_threshold_ctrl_pkg::*;

   localparam int D     = 4;
   localparam int DLY   = 20;
   localparam int PER   = 5;
   localparam int GINIT = 5;
   localparam int TSTEP = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   frame_threshold_ctrl_if bus ();

   frame_threshold_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (DLY),
      .REPEAT_PERIOD   (PER),
      .GRADE_INIT      (GINIT),
      .THR_STEP        (TSTEP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: key sample history, accepted level, stable-run
   // length, time pressed since acceptance, and grade bookkeeping.
   logic m_s1 [2];
   logic m_s2 [2];
   logic m_acc [2];
   logic m_pressed [2];
   logic m_step [2];
   int   m_run [2];
   int   m_t [2];
   logic m_vs;
   int   m_grade, m_pend, m_thr;
   logic m_upd;

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_acc[k] = 1'b1;
         m_pressed[k] = 1'b0; m_step[k] = 1'b0; m_run[k] = 0; m_t[k] = 0;
      end
      m_vs = 1'b0; m_grade = GINIT; m_pend = GINIT; m_thr = TSTEP * (GINIT + 1); m_upd = 1'b0;
   endtask

   task automatic model_update();
      logic key_in [2];
      logic prev_pr [2];
      logic lvl, acc_old;
      key_in[0] = bus.key_add_n;
      key_in[1] = bus.key_sub_n;
      if (bus.per_frame_vsync && !m_vs) begin
         m_upd   = (m_pend != m_grade);
         m_grade = m_pend;
         m_thr   = TSTEP * (m_grade + 1);
      end else begin
         m_upd = 1'b0;
      end
      m_vs = bus.per_frame_vsync;
      if (m_step[0] && !m_step[1])      m_pend = (m_pend < 15) ? m_pend + 1 : 15;
      else if (m_step[1] && !m_step[0]) m_pend = (m_pend > 0) ? m_pend - 1 : 0;
      prev_pr = m_pressed;
      for (int k = 0; k < 2; k++) begin
         lvl = m_s2[k]; m_s2[k] = m_s1[k]; m_s1[k] = key_in[k];
         acc_old = m_acc[k];
         if (lvl != m_acc[k]) m_run[k]++; else m_run[k] = 0;
         if (m_run[k] == D) begin m_acc[k] = lvl; m_run[k] = 0; end
         m_step[k] = 1'b0;
         if (acc_old) begin
            m_pressed[k] = 1'b0;
         end else if (!m_pressed[k]) begin
            m_pressed[k] = 1'b1; m_t[k] = 0; m_step[k] = 1'b1;
         end else begin
            m_t[k]++;
            if (m_t[k] >= DLY && (m_t[k] - DLY) % PER == 0 && !prev_pr[1-k]) m_step[k] = 1'b1;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst_n) model_reset(); else model_update();
      @(negedge clk);
   endtask

   function automatic logic [16:0] dut_vec();
      return {bus.Frame_Grade, bus.Frame_Threshold, bus.pending_grade, bus.thr_update};
   endfunction

   function automatic logic [16:0] model_vec();
      return {4'(m_grade), 8'(m_thr), 4'(m_pend), m_upd};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; bus.key_add_n = 1'b1; bus.key_sub_n = 1'b1; bus.per_frame_vsync = 1'b0;
      model_reset();
      repeat (3) cycle();
      n_checks++;
      if (dut_vec() !== {4'd5, 8'd30, 4'd5, 1'b0}) begin
         n_fail++; $display("FAIL reset_hold: got %h want %h", dut_vec(), {4'd5, 8'd30, 4'd5, 1'b0});
      end
      rst_n = 1'b1;
      repeat (2) cycle();
      n_checks++;
      if (dut_vec() !== {4'd5, 8'd30, 4'd5, 1'b0}) begin
         n_fail++; $display("FAIL reset_release: got %h want %h", dut_vec(), {4'd5, 8'd30, 4'd5, 1'b0});
      end
      $display("reset: grade=%0d thr=%0d pending=%0d", bus.Frame_Grade, bus.Frame_Threshold, bus.pending_grade);
   endtask

   task automatic test_single_press();
      int n_gl = $urandom_range(2, 4);
      for (int g = 0; g < n_gl; g++) begin
         bus.key_add_n = 1'b0; repeat (2) cycle();
         bus.key_add_n = 1'b1; repeat (2) cycle();
         n_checks++;
         if (bus.pending_grade !== 4'd5) begin
            n_fail++; $display("FAIL glitch_ignored: pending %0d want 5", bus.pending_grade);
         end
      end
      repeat (6) cycle();
      bus.key_add_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         n_checks++;
         if (bus.pending_grade !== ((i >= 7) ? 4'd6 : 4'd5)) begin
            n_fail++; $display("FAIL press_latency: cycle %0d pending %0d want %0d", i, bus.pending_grade, (i >= 7) ? 6 : 5);
         end
      end
      bus.key_add_n = 1'b1;
      repeat (10) cycle();
      n_checks++;
      if ({bus.pending_grade, bus.Frame_Threshold} !== {4'd6, 8'd30}) begin
         n_fail++; $display("FAIL press_before_commit: pending %0d thr %0d want 6/30", bus.pending_grade, bus.Frame_Threshold);
      end
      bus.per_frame_vsync = 1'b1; cycle();
      n_checks++;
      if ({bus.Frame_Grade, bus.Frame_Threshold, bus.thr_update} !== {4'd6, 8'd35, 1'b1}) begin
         n_fail++; $display("FAIL press_commit: grade %0d thr %0d upd %0b want 6/35/1", bus.Frame_Grade, bus.Frame_Threshold, bus.thr_update);
      end
      cycle();
      n_checks++;
      if (bus.thr_update !== 1'b0) begin
         n_fail++; $display("FAIL upd_one_cycle: upd %0b want 0", bus.thr_update);
      end
      bus.per_frame_vsync = 1'b0; repeat (2) cycle();
      $display("single_press: glitches=%0d pending=%0d thr=%0d", n_gl, bus.pending_grade, bus.Frame_Threshold);
   endtask

   task automatic test_hold_sub();
      bus.key_sub_n = 1'b0;
      for (int i = 0; i < D + 3 + 60; i++) begin
         cycle();
         n_checks++;
         if (bus.pending_grade !== 4'(m_pend)) begin
            n_fail++; $display("FAIL sub_repeat: cycle %0d pending %0d want %0d", i, bus.pending_grade, m_pend);
         end
      end
      bus.key_sub_n = 1'b1; repeat (10) cycle();
      n_checks++;
      if (bus.pending_grade !== 4'd0) begin
         n_fail++; $display("FAIL sub_saturate: pending %0d want 0", bus.pending_grade);
      end
      bus.per_frame_vsync = 1'b1; cycle();
      n_checks++;
      if ({bus.Frame_Grade, bus.Frame_Threshold, bus.thr_update} !== {4'd0, 8'd5, 1'b1}) begin
         n_fail++; $display("FAIL sub_commit: grade %0d thr %0d upd %0b want 0/5/1", bus.Frame_Grade, bus.Frame_Threshold, bus.thr_update);
      end
      bus.per_frame_vsync = 1'b0; repeat (2) cycle();
      $display("hold_sub: pending=%0d thr=%0d", bus.pending_grade, bus.Frame_Threshold);
   endtask

   task automatic test_hold_add_sat();
      bus.key_add_n = 1'b0;
      for (int i = 0; i < 120; i++) begin
         cycle();
         n_checks++;
         if (bus.pending_grade !== 4'(m_pend)) begin
            n_fail++; $display("FAIL add_repeat: cycle %0d pending %0d want %0d", i, bus.pending_grade, m_pend);
         end
      end
      bus.key_add_n = 1'b1; repeat (10) cycle();
      n_checks++;
      if (bus.pending_grade !== 4'd15) begin
         n_fail++; $display("FAIL add_saturate: pending %0d want 15", bus.pending_grade);
      end
      bus.per_frame_vsync = 1'b1; cycle();
      n_checks++;
      if ({bus.Frame_Grade, bus.Frame_Threshold, bus.thr_update} !== {4'd15, 8'd80, 1'b1}) begin
         n_fail++; $display("FAIL add_commit: grade %0d thr %0d upd %0b want 15/80/1", bus.Frame_Grade, bus.Frame_Threshold, bus.thr_update);
      end
      bus.per_frame_vsync = 1'b0;
      bus.key_add_n = 1'b0; repeat (30) cycle();
      bus.key_add_n = 1'b1; repeat (10) cycle();
      bus.per_frame_vsync = 1'b1; cycle();
      n_checks++;
      if ({bus.pending_grade, bus.Frame_Threshold, bus.thr_update} !== {4'd15, 8'd80, 1'b0}) begin
         n_fail++; $display("FAIL add_stays_max: pending %0d thr %0d upd %0b want 15/80/0", bus.pending_grade, bus.Frame_Threshold, bus.thr_update);
      end
      bus.per_frame_vsync = 1'b0; repeat (2) cycle();
      $display("hold_add_sat: pending=%0d thr=%0d", bus.pending_grade, bus.Frame_Threshold);
   endtask

   task automatic test_both_keys();
      int hold = $urandom_range(30, 50);
      int gap  = $urandom_range(2, 4);
      bus.key_add_n = 1'b0; bus.key_sub_n = 1'b0;
      for (int i = 0; i < hold; i++) begin
         cycle();
         n_checks++;
         if (bus.pending_grade !== 4'd15) begin
            n_fail++; $display("FAIL both_simultaneous: cycle %0d pending %0d want 15", i, bus.pending_grade);
         end
      end
      bus.key_add_n = 1'b1; bus.key_sub_n = 1'b1; repeat (10) cycle();
      bus.per_frame_vsync = 1'b1; cycle();
      n_checks++;
      if ({bus.Frame_Threshold, bus.thr_update} !== {8'd80, 1'b0}) begin
         n_fail++; $display("FAIL both_commit: thr %0d upd %0b want 80/0", bus.Frame_Threshold, bus.thr_update);
      end
      bus.per_frame_vsync = 1'b0;
      // Staggered press: initial steps count, repeats pause while both are held.
      bus.key_add_n = 1'b0; repeat (gap) cycle();
      bus.key_sub_n = 1'b0;
      for (int i = 0; i < 70; i++) begin
         if (i == 45) bus.key_add_n = 1'b1;
         cycle();
         n_checks++;
         if (bus.pending_grade !== 4'(m_pend)) begin
            n_fail++; $display("FAIL both_staggered: cycle %0d pending %0d want %0d", i, bus.pending_grade, m_pend);
         end
      end
      bus.key_sub_n = 1'b1; repeat (10) cycle();
      bus.per_frame_vsync = 1'b1; cycle();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
         n_fail++; $display("FAIL both_staggered_commit: got %h want %h", dut_vec(), model_vec());
      end
      bus.per_frame_vsync = 1'b0; repeat (3) cycle();
      $display("both_keys: hold=%0d gap=%0d pending=%0d", hold, gap, bus.pending_grade);
   endtask

   task automatic test_coincident_vsync();
      int p0, p_new;
      logic use_add;
      p0 = m_pend;
      use_add = (p0 < 15);
      p_new = use_add ? p0 + 1 : p0 - 1;
      if (use_add) bus.key_add_n = 1'b0; else bus.key_sub_n = 1'b0;
      repeat (7) cycle();
      n_checks++;
      if (bus.pending_grade !== 4'(p0)) begin
         n_fail++; $display("FAIL coincident_pre: pending %0d want %0d", bus.pending_grade, p0);
      end
      bus.per_frame_vsync = 1'b1; cycle();
      n_checks++;
      if ({bus.Frame_Grade, bus.pending_grade} !== {4'(p0), 4'(p_new)}) begin
         n_fail++; $display("FAIL coincident_deferred: grade %0d pending %0d want %0d/%0d", bus.Frame_Grade, bus.pending_grade, p0, p_new);
      end
      bus.key_add_n = 1'b1; bus.key_sub_n = 1'b1;
      repeat (3) cycle();
      bus.per_frame_vsync = 1'b0; repeat (10) cycle();
      bus.per_frame_vsync = 1'b1; cycle();
      n_checks++;
      if ({bus.Frame_Grade, bus.Frame_Threshold, bus.thr_update} !== {4'(p_new), 8'(TSTEP * (p_new + 1)), 1'b1}) begin
         n_fail++; $display("FAIL coincident_next_frame: grade %0d thr %0d upd %0b want %0d/%0d/1", bus.Frame_Grade, bus.Frame_Threshold, bus.thr_update, p_new, TSTEP * (p_new + 1));
      end
      bus.per_frame_vsync = 1'b0; repeat (2) cycle();
      $display("coincident_vsync: p0=%0d committed=%0d", p0, bus.Frame_Grade);
   endtask

   task automatic test_reset_mid_repeat();
      if (m_pend > 0) bus.key_sub_n = 1'b0; else bus.key_add_n = 1'b0;
      repeat (35) cycle();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (dut_vec() !== {4'd5, 8'd30, 4'd5, 1'b0}) begin
         n_fail++; $display("FAIL reset_mid_repeat: got %h want %h", dut_vec(), {4'd5, 8'd30, 4'd5, 1'b0});
      end
      bus.key_add_n = 1'b1; bus.key_sub_n = 1'b1;
      @(negedge clk);
      repeat (3) cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         cycle();
         n_checks++;
         if (bus.pending_grade !== 4'd5) begin
            n_fail++; $display("FAIL no_step_after_reset: cycle %0d pending %0d want 5", i, bus.pending_grade);
         end
      end
      bus.key_add_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         n_checks++;
         if (bus.pending_grade !== ((i >= 7) ? 4'd6 : 4'd5)) begin
            n_fail++; $display("FAIL fresh_press: cycle %0d pending %0d want %0d", i, bus.pending_grade, (i >= 7) ? 6 : 5);
         end
      end
      bus.key_add_n = 1'b1; repeat (10) cycle();
      $display("reset_mid_repeat: pending=%0d thr=%0d", bus.pending_grade, bus.Frame_Threshold);
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 11) == 0) bus.key_add_n = ~bus.key_add_n;
         if ($urandom_range(0, 11) == 0) bus.key_sub_n = ~bus.key_sub_n;
         if ($urandom_range(0, 14) == 0) bus.per_frame_vsync = ~bus.per_frame_vsync;
         cycle();
         n_checks++;
         if (dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL random: cycle %0d got %h want %h", i, dut_vec(), model_vec());
         end
         if (bus.thr_update === 1'b1)
            $display("commit: cycle %0d grade=%0d thr=%0d", i, bus.Frame_Grade, bus.Frame_Threshold);
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_hold_sub();
      test_hold_add_sat();
      test_both_keys();
      test_coincident_vsync();
      test_reset_mid_repeat();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_threshold_ctrl.md
# frame_threshold_ctrl

Key-driven controller that sequences threshold changes for the frame-difference / Sobel binarisation datapath. It debounces two raw push-buttons and adds hold-to-repeat stepping. It keeps a pending grade and commits the grade and threshold to the datapath only at a frame boundary, so a threshold never changes mid-frame. It sits between the board keys and the threshold input of the detection pipeline, and also drives the grade display.

## Interface
- DEBOUNCE_CYCLES, 2_000_000: cycles a synchronised key level must stay stable before it is accepted (20 ms at 100 MHz).
- REPEAT_DELAY, 50_000_000: cycles a key must be held after acceptance before auto-repeat starts.
- REPEAT_PERIOD, 10_000_000: cycles between auto-repeat steps.
- GRADE_INIT, 5: grade after reset (0..15).
- THR_STEP, 5: threshold increment per grade.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset. One clock, no other reset.
- key_add_n  in  1  raw increment button, active-low, asynchronous to clk.
- key_sub_n  in  1  raw decrement button, active-low, asynchronous to clk.
- per_frame_vsync  in  1  frame sync of the video stream, synchronous to clk, high = frame active.
- Frame_Grade  out  4  committed grade.
- Frame_Threshold  out  8  committed threshold = THR_STEP*(Frame_Grade+1).
- pending_grade  out  4  grade that will be committed at the next frame start.
- thr_update  out  1  one-cycle pulse when a commit changes Frame_Grade.

## Operation
- Each key passes through a 2-FF synchroniser, then a debounce counter. The counter reloads on any change of the synchronised level. The new level is accepted when the count reaches DEBOUNCE_CYCLES.
- Per-key FSM, states IDLE, HOLD and REPEAT:
  - IDLE→HOLD on accepted press; emits one step pulse on that cycle.
  - HOLD→REPEAT after REPEAT_DELAY cycles still pressed; emits a step on entry.
  - REPEAT emits a step every REPEAT_PERIOD cycles.
  - Accepted release from any state → IDLE, with no pulse.
- Step arbitration:
  - add and sub steps in the same cycle: both are dropped.
  - Both keys held, i.e. both FSMs not IDLE: repeat steps from both are suppressed.
- pending_grade saturates at both ends. add at 15 stays 15; sub at 0 stays 0. There is no wrap-around.
- Commit happens on the vsync rising edge (per_frame_vsync=1 while the registered copy is 0):
  - Frame_Grade ← pending_grade.
  - Frame_Threshold ← THR_STEP*(pending_grade+1), in 8-bit arithmetic. At defaults the range is 5..80. Parameter choices that overflow 8 bits are illegal; add an elaboration check.
  - thr_update=1 only if the committed value differs from the old Frame_Grade.
- Steps arriving between commits accumulate in pending_grade. Only the final value is committed.
- Reset values:
  - Frame_Grade = pending_grade = GRADE_INIT.
  - Frame_Threshold = THR_STEP*(GRADE_INIT+1) (30 at defaults).
  - thr_update = 0; FSMs in IDLE.
  - Synchronisers and debounced levels reset to 1 (released).
  - Registered vsync resets to 0, so vsync already high at reset release triggers a commit.

## Timing
- Key edge to step pulse: 2 synchroniser cycles + DEBOUNCE_CYCLES + 1 cycle.
- Step pulse to pending_grade update: 1 cycle.
- vsync rising edge sampled in cycle N: registered vsync, detection and commit register update together. Frame_Grade, Frame_Threshold and thr_update are valid in cycle N+1. thr_update is high for exactly cycle N+1.
- A step in the same cycle as commit detection is not in the commit. It lands in pending_grade and goes out at the next frame.
- Reset asserted mid-hold or mid-repeat: immediate return to reset values. No step is emitted after release until a fresh debounced press.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - GRADE_W=4, THR_W=8, GRADE_MAX=4'd15, GRADE_MIN=4'd0.
  - The key FSM state encoding: IDLE, HOLD, REPEAT (2 bits).
- One sub-module, key_debounce_repeat, instantiated twice (add, sub). It contains the synchroniser, debounce counter, repeat FSM and counter, and has outputs step and held.
- The top level holds arbitration, pending_grade saturation, vsync edge detect, the commit registers and the threshold multiply.

## Test plan
Simulation parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, GRADE_INIT=5, THR_STEP=5.

1. Reset release with vsync low → Frame_Grade=5, Frame_Threshold=30, pending_grade=5, thr_update=0.
2. Single press of key_add_n with 2-cycle glitches before a clean level → exactly one step; pending_grade=6. Frame_Threshold stays 30 until the vsync rising edge, then becomes 35, with a 1-cycle thr_update.
3. Hold key_sub_n for 60 cycles after acceptance → 1 initial step, then repeats every 5 cycles after 20 cycles: pending_grade 5→4→3→2→1→0, saturating at 0. At the next frame start Frame_Threshold=5.
4. Hold key_add_n from grade 14 through several repeats → pending_grade stops at 15. At commit Frame_Threshold=80; further steps leave 15.
5. Press both keys simultaneously → no change to pending_grade. The commit at vsync gives thr_update=0 and Frame_Threshold unchanged.
6. Step pulse coincident with the vsync rising edge, and separately rst_n asserted mid-REPEAT:
   - The coincident step is committed at the following frame, not the current one.
   - After reset, outputs return to 5/30 and no step occurs until a new debounced press.
